// File: rtl/uart_pkg.sv
// Shared UART definitions: serializer states and 8N1 frame constants.
package uart_pkg;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START_BIT,
    TX_DATA_BITS,
    TX_STOP_BIT
  } uart_state_e;

  localparam int FIFO_BITS_DEF = 4;
  localparam int DATA_BITS     = 8;
  localparam int FRAME_BITS    = 10;

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);
  localparam logic       LINE_IDLE = 1'b1;
  localparam logic       START_LVL = 1'b0;

endpackage

// File: rtl/uart_tx_if.sv
// Bus-side write port of the UART transmitter.
interface uart_tx_if;
  import uart_pkg::*;

  logic                 stb_i;
  logic                 cyc_i;
  logic [DATA_BITS-1:0] data_i;
  logic                 ack_o;

  modport master (
    output stb_i,
    output cyc_i,
    output data_i,
    input  ack_o
  );

  modport slave (
    input  stb_i,
    input  cyc_i,
    input  data_i,
    output ack_o
  );

endinterface

// File: rtl/uart_tx_fifo.sv
// TX byte FIFO; fullness tracked by a separate count so every entry is usable.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int BITS = FIFO_BITS_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 push,
  input  logic [DATA_BITS-1:0] wdata,
  input  logic                 pop,
  output logic [DATA_BITS-1:0] rdata,
  output logic                 full,
  output logic                 empty
);

  localparam int DEPTH = 2 ** BITS;
  localparam logic [BITS:0] DEPTH_C = (BITS + 1)'(DEPTH);

  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [BITS-1:0]      wr_ptr;
  logic [BITS-1:0]      rd_ptr;
  logic [BITS:0]        count;
  logic                 push_ok;
  logic                 pop_ok;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: bus write port into a byte FIFO, drained by a bit serializer.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 62,
  parameter int FIFO_BITS    = FIFO_BITS_DEF
) (
  input  logic     clk_i,
  input  logic     rst_i,
  uart_tx_if.slave bus,
  output logic     tx_busy_o,
  output logic     uart_txd_o
);

  localparam logic [15:0] CPB = 16'(CLKS_PER_BIT);

  uart_state_e          state, state_n;
  logic [15:0]          clk_cnt, clk_cnt_n;
  logic [2:0]           bit_idx, bit_idx_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic                 txd, txd_n;
  logic                 sync_ack;
  logic                 push;
  logic                 pop;
  logic                 full;
  logic                 empty;
  logic [DATA_BITS-1:0] rdata;
  logic                 bit_done;

  uart_tx_fifo #(
    .BITS (FIFO_BITS)
  ) u_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (push),
    .wdata (bus.data_i),
    .pop   (pop),
    .rdata (rdata),
    .full  (full),
    .empty (empty)
  );

  // One byte per strobe: sync_ack blocks re-accept until stb_i drops.
  assign push       = bus.stb_i & bus.cyc_i & ~sync_ack & ~full;
  assign bus.ack_o  = sync_ack & bus.stb_i;
  assign tx_busy_o  = ~empty | (state != TX_IDLE);
  assign uart_txd_o = txd;
  assign bit_done   = (clk_cnt == CPB);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_ack <= 1'b0;
    end else if (push) begin
      sync_ack <= 1'b1;
    end else if (!bus.stb_i) begin
      sync_ack <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= TX_IDLE;
      clk_cnt <= '0;
      bit_idx <= '0;
      shift   <= '0;
      txd     <= LINE_IDLE;
    end else begin
      state   <= state_n;
      clk_cnt <= clk_cnt_n;
      bit_idx <= bit_idx_n;
      shift   <= shift_n;
      txd     <= txd_n;
    end
  end

  always_comb begin
    state_n   = state;
    clk_cnt_n = clk_cnt + 16'd1;
    bit_idx_n = bit_idx;
    shift_n   = shift;
    txd_n     = txd;
    pop       = 1'b0;
    unique case (state)
      TX_IDLE: begin
        clk_cnt_n = '0;
        txd_n     = LINE_IDLE;
        if (!empty) begin
          pop       = 1'b1;
          shift_n   = rdata;
          txd_n     = START_LVL;
          clk_cnt_n = 16'd1;
          state_n   = TX_START_BIT;
        end
      end
      TX_START_BIT: begin
        if (bit_done) begin
          clk_cnt_n = 16'd1;
          bit_idx_n = '0;
          txd_n     = shift[0];
          state_n   = TX_DATA_BITS;
        end
      end
      TX_DATA_BITS: begin
        if (bit_done) begin
          clk_cnt_n = 16'd1;
          if (bit_idx == LAST_BIT) begin
            txd_n   = LINE_IDLE;
            state_n = TX_STOP_BIT;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
            shift_n   = shift >> 1;
            txd_n     = shift[1];
          end
        end
      end
      TX_STOP_BIT: begin
        if (bit_done) begin
          clk_cnt_n = '0;
          state_n   = TX_IDLE;
        end
      end
      default: begin
        clk_cnt_n = '0;
        txd_n     = LINE_IDLE;
        state_n   = TX_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: frame-schedule model, per-cycle compare, reference line decoder.
module tb_uart_tx;

  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tx_busy;
  logic txd;

  uart_tx_if bus ();

  uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_BITS    (4)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .bus        (bus),
    .tx_busy_o  (tx_busy),
    .uart_txd_o (txd)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Model: each accepted byte becomes a frame with a known start edge.
  int          m_edge = 0;
  int          f_acc[$];
  int          f_start[$];
  logic [7:0]  f_data[$];
  bit          m_sync = 1'b0;
  bit          cmp_en = 1'b0;

  function automatic int occupancy(input int e);
    int n = 0;
    foreach (f_acc[i]) if (f_acc[i] < e) n++;
    foreach (f_start[i]) if (f_start[i] < e) n--;
    return n;
  endfunction

  function automatic logic exp_txd(input int e);
    int b;
    foreach (f_start[i]) begin
      if (e >= f_start[i] && e < f_start[i] + FRAME) begin
        b = (e - f_start[i]) / CPB;
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return f_data[i][b-1];
      end
    end
    return 1'b1;
  endfunction

  function automatic logic exp_busy(input int e);
    foreach (f_acc[i])
      if (f_acc[i] <= e && e < f_start[i] + FRAME) return 1'b1;
    return 1'b0;
  endfunction

  initial begin : model
    int s;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        f_acc.delete();
        f_start.delete();
        f_data.delete();
        m_sync = 1'b0;
      end else begin
        m_edge++;
        if (bus.stb_i && bus.cyc_i && !m_sync &&
            occupancy(m_edge) < DEPTH) begin
          s = m_edge + 1;
          if (f_start.size() > 0 && f_start[$] + FRAME + 1 > s)
            s = f_start[$] + FRAME + 1;
          f_acc.push_back(m_edge);
          f_start.push_back(s);
          f_data.push_back(bus.data_i);
          m_sync = 1'b1;
        end else if (!bus.stb_i) begin
          m_sync = 1'b0;
        end
      end
    end
  end

  initial begin : compare
    forever begin
      @(negedge clk);
      #1;
      if (cmp_en && !rst) begin
        chk("txd", txd, exp_txd(m_edge));
        chk("busy", tx_busy, exp_busy(m_edge));
        chk("ack", bus.ack_o, m_sync & bus.stb_i);
      end
    end
  end

  // Reference receiver: mid-bit sampling of the line.
  logic [7:0] rx_got[$];

  initial begin : rx_ref
    int ph;
    int b;
    logic [7:0] sh;
    ph = -1;
    sh = '0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        ph = -1;
      end else if (ph < 0) begin
        if (txd == 1'b0) ph = 0;
      end else begin
        ph++;
        if (ph % CPB == CPB / 2) begin
          b = ph / CPB;
          if (b == 0) begin
            chk("rx_start", txd, 1'b0);
          end else if (b <= 8) begin
            sh[b-1] = txd;
          end else begin
            chk("rx_stop", txd, 1'b1);
            rx_got.push_back(sh);
            ph = -1;
          end
        end
      end
    end
  end

  task automatic wr(input logic [7:0] d, input int hold, output int n);
    n = 0;
    @(negedge clk);
    bus.stb_i  = 1'b1;
    bus.cyc_i  = 1'b1;
    bus.data_i = d;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.ack_o && n < 3000);
    if (!bus.ack_o) begin
      errors++;
      checks++;
      $display("FAIL ack_timeout: no ack for %h, required ack", d);
    end
    repeat (hold) @(negedge clk);
    bus.stb_i = 1'b0;
    bus.cyc_i = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (tx_busy && n < 5000);
    if (tx_busy) begin
      errors++;
      checks++;
      $display("FAIL idle_timeout: busy=1, required 0");
    end
    repeat (4) @(negedge clk);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation ran past time limit");
    $fatal(1, "watchdog");
  end

  int pat55[10] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};

  initial begin : stim
    int w;
    int w16;
    int w17;
    logic [7:0] sent[$];
    logic [7:0] d;
    bus.stb_i  = 1'b0;
    bus.cyc_i  = 1'b0;
    bus.data_i = '0;

    // reset state
    @(negedge clk);
    #1;
    chk("rst_txd", txd, 1'b1);
    chk("rst_busy", tx_busy, 1'b0);
    chk("rst_ack", bus.ack_o, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cmp_en = 1'b1;
    repeat (3) @(negedge clk);

    // single byte 0x55, literal waveform
    bus.stb_i  = 1'b1;
    bus.cyc_i  = 1'b1;
    bus.data_i = 8'h55;
    #1 chk("ack_pre", bus.ack_o, 1'b0);
    @(negedge clk);
    #1;
    chk("ack_lat", bus.ack_o, 1'b1);
    chk("txd_pre", txd, 1'b1);
    #1;
    bus.stb_i = 1'b0;
    bus.cyc_i = 1'b0;
    #1 chk("ack_drop", bus.ack_o, 1'b0);
    for (int k = 0; k < 10; k++) begin
      repeat (k == 0 ? 2 : 4) @(negedge clk);
      #1 chk($sformatf("b55_%0d", k), txd, pat55[k]);
    end
    repeat (2) @(negedge clk);
    #1 chk("busy_last", tx_busy, 1'b1);
    @(negedge clk);
    #1 chk("busy_end", tx_busy, 1'b0);
    wait_idle();
    chk("rx55_n", rx_got.size(), 1);
    if (rx_got.size() > 0) chk("rx55", rx_got[0], 8'h55);

    // back-to-back 0x00, 0xFF
    rx_got.delete();
    wr(8'h00, 0, w);
    wr(8'hFF, 0, w);
    wait_idle();
    chk("b2b_n", rx_got.size(), 2);
    if (rx_got.size() > 1) begin
      chk("b2b_0", rx_got[0], 8'h00);
      chk("b2b_1", rx_got[1], 8'hFF);
    end

    // cyc low: strobe ignored
    @(negedge clk);
    bus.stb_i = 1'b1;
    repeat (6) @(negedge clk);
    #1 chk("nocyc_busy", tx_busy, 1'b0);
    bus.stb_i = 1'b0;

    // fill past full
    rx_got.delete();
    w16 = 0;
    w17 = 0;
    for (int i = 0; i < 18; i++) begin
      wr(8'(8'h10 + i), 0, w);
      if (i == 16) w16 = w;
      if (i == 17) w17 = w;
    end
    chk("fill_ack16", w16, 1);
    chk("full_stall", w17, 10);
    wait_idle();
    chk("fill_n", rx_got.size(), 18);
    for (int i = 0; i < 18; i++)
      if (i < rx_got.size())
        chk($sformatf("fill_%0d", i), rx_got[i], 8'(8'h10 + i));

    // stb held after ack
    rx_got.delete();
    wr(8'h3C, 5, w);
    wait_idle();
    chk("hold_n", rx_got.size(), 1);
    if (rx_got.size() > 0) chk("hold", rx_got[0], 8'h3C);

    // reset during data bit 3 of 0xA5
    rx_got.delete();
    wr(8'hA5, 0, w);
    repeat (18) @(negedge clk);
    #1 chk("a5_bit3", txd, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("arst_txd", txd, 1'b1);
    chk("arst_busy", tx_busy, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    rx_got.delete();
    wr(8'h96, 0, w);
    wait_idle();
    chk("post_rst_n", rx_got.size(), 1);
    if (rx_got.size() > 0) chk("post_rst", rx_got[0], 8'h96);

    // loopback of random bytes
    rx_got.delete();
    for (int i = 0; i < 16; i++) begin
      d = 8'($urandom_range(0, 255));
      sent.push_back(d);
      wr(d, 0, w);
    end
    wait_idle();
    chk("loop_n", rx_got.size(), 16);
    for (int i = 0; i < 16; i++)
      if (i < rx_got.size())
        chk($sformatf("loop_%0d", i), rx_got[i], sent[i]);

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
